// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Purpose  : MEM-stage load/store unit. Muxes forwarded store data, drives a
//             req/ready data-memory port, formats load results, and stalls
//             the pipeline while an access is outstanding.
//  Ports    : clk, rst_n (sync, active-low)
//             mem_*            - instruction fields from Reg_EX_MEM
//             wb_wr_data,
//             ForwardStoreSel  - store-data forwarding from WB
//             dmem_*           - data-memory request/response port
//             mem_stall        - freeze IF..MEM, bubble into WB
//             load_data/valid  - formatted load result (one-cycle valid)
//             mem_exc          - 00 none, 01 misaligned, 10 illegal, 11 bus err
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_MemRd,
    input  logic        mem_MemWr,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_rs2_data,
    input  logic [31:0] wb_wr_data,
    input  logic        ForwardStoreSel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic [1:0]  mem_exc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter value on the last permitted WAIT cycle without ready.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISAL = 2'b01;
    localparam logic [1:0] EXC_ILL   = 2'b10;
    localparam logic [1:0] EXC_BUS   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] ld_q, ld_d;
    logic        lv_q, lv_d;
    logic [1:0]  exc_q, exc_d;

    // ---------------- request decode ----------------
    logic        is_load, is_store, legal, aligned;
    logic        in_idle, start, misal, illegal, timeout;
    logic [31:0] st_sel, st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign is_load  = mem_MemRd & ~mem_MemWr;
    assign is_store = mem_MemWr & ~mem_MemRd;

    always_comb begin
        legal = 1'b0;
        if (is_load) begin
            case (mem_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (mem_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (mem_funct3[1:0])
            2'b01:   aligned = ~mem_addr[0];
            2'b10:   aligned = (mem_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign in_idle = (state_q == S_IDLE);
    assign start   = in_idle & mem_valid & legal & aligned;
    // Misaligned is only reported for an otherwise legal access.
    assign misal   = in_idle & mem_valid & legal & ~aligned;
    assign illegal = in_idle & mem_valid &
                     ((mem_MemRd & mem_MemWr) | ((mem_MemRd ^ mem_MemWr) & ~legal));
    assign timeout = (state_q == S_WAIT) & ~dmem_ready & (cnt_q == TIMEOUT_LAST);

    assign mem_stall = rst_n & (start | (state_q == S_WAIT));

    // ---------------- store formatting ----------------
    assign st_sel = ForwardStoreSel ? wb_wr_data : mem_rs2_data;

    always_comb begin
        case (mem_funct3[1:0])
            2'b00: begin
                st_wdata = {4{st_sel[7:0]}};
                st_wstrb = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{st_sel[15:0]}};
                st_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
            end
            default: begin
                st_wdata = st_sel;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // ---------------- load formatting (latched offset/size) ----------------
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            ld_q     <= 32'd0;
            lv_q     <= 1'b0;
            exc_q    <= EXC_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            ld_q     <= ld_d;
            lv_q     <= lv_d;
            exc_q    <= exc_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (dmem_ready || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        ld_d     = ld_q;
        lv_d     = 1'b0;
        exc_d    = EXC_NONE;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    // Store data is captured now: WB only sees bubbles during
                    // the stall, so the forwarded value would be lost later.
                    req_d    = 1'b1;
                    we_d     = is_store;
                    addr_d   = {mem_addr[31:2], 2'b00};
                    funct3_d = mem_funct3;
                    off_d    = mem_addr[1:0];
                    wdata_d  = is_store ? st_wdata : 32'd0;
                    wstrb_d  = is_store ? st_wstrb : 4'd0;
                end else if (illegal) begin
                    exc_d = EXC_ILL;
                end else if (misal) begin
                    exc_d = EXC_MISAL;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    cnt_d = 8'd0;
                    if (!we_q) begin
                        ld_d = ld_fmt;
                        lv_d = 1'b1;
                    end
                end else if (timeout) begin
                    // Bus error: no valid data is delivered, only the exception.
                    req_d = 1'b0;
                    cnt_d = 8'd0;
                    ld_d  = 32'd0;
                    exc_d = EXC_BUS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = ld_q;
    assign load_valid = lv_q;
    assign mem_exc    = exc_q;

endmodule
`default_nettype wire
